// File: rtl/router_pkg.sv
// Shared router types: flit format, destination-ID field position and the credit record.
// Route compute, the allocators and the input buffers all import this package.
package router_pkg;

  localparam int unsigned FLIT_DATA_WIDTH = 16;
  localparam int unsigned DEST_ID_WIDTH   = 4;
  localparam int unsigned DEST_ID_LSB     = FLIT_DATA_WIDTH - DEST_ID_WIDTH;
  localparam int unsigned VC_INDEX_WIDTH  = 2;

  typedef logic [FLIT_DATA_WIDTH-1:0] flit_t;

  typedef struct packed {
    logic                      valid;
    logic [VC_INDEX_WIDTH-1:0] vc;
  } credit_t;

  function automatic logic [DEST_ID_WIDTH-1:0] flit_dest(input flit_t flit);
    return flit[FLIT_DATA_WIDTH-1 -: DEST_ID_WIDTH];
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular FIFO with wrap-bit pointers and a masked head output.
// The caller gates push/pop; this block never checks full/empty on its own inputs.
module vc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage is deliberately left unreset; head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= din;
  end

  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    head  = empty ? '0 : mem[rptr_q[AW-1:0]];
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Per-input-port VC buffer: demuxes link flits into per-VC FIFOs, exposes heads and
// occupancy, and on a switch-stage pop registers the flit out and returns a credit.
module input_vc_buffer
  import router_pkg::*;
#(
  parameter int unsigned NUM_VC     = 4,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter int unsigned FLIT_WIDTH = FLIT_DATA_WIDTH,
  parameter int unsigned VC_BITS    = $clog2(NUM_VC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [VC_BITS-1:0]           in_vc,
  input  logic [FLIT_WIDTH-1:0]        in_flit,
  input  logic                         rd_valid,
  input  logic [VC_BITS-1:0]           rd_vc,
  output logic [NUM_VC*FLIT_WIDTH-1:0] head_flit,
  output logic [NUM_VC-1:0]            vc_not_empty,
  output logic                         out_valid,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         credit_valid,
  output logic [VC_BITS-1:0]           credit_vc,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  logic [NUM_VC-1:0]     push, pop, full, empty;
  logic [FLIT_WIDTH-1:0] head_arr [NUM_VC];

  logic                  pop_ok, pop_same, write_ok;
  logic                  out_valid_q, out_valid_d;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  credit_t               credit_q, credit_d;
  logic                  err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

  // A full VC still accepts a write when the same VC is popped this cycle.
  always_comb begin
    pop_ok   = rd_valid && !empty[rd_vc];
    pop_same = rd_valid && (rd_vc == in_vc);
    write_ok = in_valid && (!full[in_vc] || pop_same);
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v] = write_ok && (in_vc == VC_BITS'(v));
    assign pop[v]  = pop_ok && (rd_vc == VC_BITS'(v));

    vc_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (FLIT_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (in_flit),
      .head  (head_arr[v]),
      .full  (full[v]),
      .empty (empty[v])
    );

    assign head_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = head_arr[v];
  end

  always_comb begin
    out_valid_d    = pop_ok;
    out_flit_d     = out_flit_q;
    credit_d       = '0;
    credit_d.valid = pop_ok;
    credit_d.vc    = credit_q.vc;
    err_ovf_d      = err_ovf_q;
    err_unf_d      = err_unf_q;
    if (pop_ok) begin
      out_flit_d  = head_arr[rd_vc];
      credit_d.vc = VC_INDEX_WIDTH'(rd_vc);
    end
    if (in_valid && !write_ok) err_ovf_d = 1'b1;
    if (rd_valid && !pop_ok)   err_unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      credit_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      credit_q    <= credit_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign vc_not_empty  = ~empty;
  assign out_valid     = out_valid_q;
  assign out_flit      = out_flit_q;
  assign credit_valid  = credit_q.valid;
  assign credit_vc     = VC_BITS'(credit_q.vc);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed table-driven bench for input_vc_buffer plus a hand-written mid-stream reset.
module tb_input_vc_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic [15:0] in_flit;
  logic        rd_valid;
  logic [1:0]  rd_vc;
  logic [63:0] head_flit;
  logic [3:0]  vc_not_empty;
  logic        out_valid;
  logic [15:0] out_flit;
  logic        credit_valid;
  logic [1:0]  credit_vc;
  logic        err_overflow;
  logic        err_underflow;

  int n_checks = 0;
  int n_err    = 0;

  input_vc_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_vc         (in_vc),
    .in_flit       (in_flit),
    .rd_valid      (rd_valid),
    .rd_vc         (rd_vc),
    .head_flit     (head_flit),
    .vc_not_empty  (vc_not_empty),
    .out_valid     (out_valid),
    .out_flit      (out_flit),
    .credit_valid  (credit_valid),
    .credit_vc     (credit_vc),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  ivc;
    logic [15:0] ifl;
    logic        rv;
    logic [1:0]  rvc;
    logic [3:0]  ne;
    logic        ov;   // expected out_valid and credit_valid
    logic [15:0] ofl;
    logic [1:0]  cvc;
    logic [1:0]  hvc;  // which VC's head to check
    logic [15:0] hd;
    logic        eo;
    logic        eu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [1:0] ivc, input logic [15:0] ifl,
                              input logic rv, input logic [1:0] rvc, input logic [3:0] ne,
                              input logic ov, input logic [15:0] ofl, input logic [1:0] cvc,
                              input logic [1:0] hvc, input logic [15:0] hd,
                              input logic eo, input logic eu);
    vec_t v;
    v.iv = iv; v.ivc = ivc; v.ifl = ifl; v.rv = rv; v.rvc = rvc; v.ne = ne;
    v.ov = ov; v.ofl = ofl; v.cvc = cvc; v.hvc = hvc; v.hd = hd; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    in_valid = v.iv; in_vc = v.ivc; in_flit = v.ifl;
    rd_valid = v.rv; rd_vc = v.rvc;
    @(posedge clk);
    #1;
    check({tag, " vc_not_empty"}, 64'(vc_not_empty), 64'(v.ne));
    check({tag, " out_valid"}, 64'(out_valid), 64'(v.ov));
    check({tag, " credit_valid"}, 64'(credit_valid), 64'(v.ov));
    if (v.ov) begin
      check({tag, " out_flit"}, 64'(out_flit), 64'(v.ofl));
      check({tag, " credit_vc"}, 64'(credit_vc), 64'(v.cvc));
    end
    check({tag, " head_flit"}, 64'(head_flit[v.hvc*16 +: 16]), 64'(v.hd));
    check({tag, " err_overflow"}, 64'(err_overflow), 64'(v.eo));
    check({tag, " err_underflow"}, 64'(err_underflow), 64'(v.eu));
    in_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " out_flit"}, 64'(out_flit), 64'd0);
    check({tag, " credit_valid"}, 64'(credit_valid), 64'd0);
    check({tag, " credit_vc"}, 64'(credit_vc), 64'd0);
    check({tag, " vc_not_empty"}, 64'(vc_not_empty), 64'd0);
    check({tag, " head_flit"}, head_flit, 64'd0);
    check({tag, " err_overflow"}, 64'(err_overflow), 64'd0);
    check({tag, " err_underflow"}, 64'(err_underflow), 64'd0);
  endtask

  initial begin
    // Single write/pop on VC2
    vecs.push_back(mk(1, 2, 16'hA1, 0, 0, 4'b0100, 0, 0, 0, 2, 16'hA1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 4'b0000, 1, 16'hA1, 2, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2, 0, 0, 0));
    // Fill VC1, then write into full VC1 with a same-cycle pop, then drain
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, 16'(16'h30 + i), 0, 0, 4'b0010, 0, 0, 0, 1, 16'h30, 0, 0));
    vecs.push_back(mk(1, 1, 16'h55, 1, 1, 4'b0010, 1, 16'h30, 1, 1, 16'h31, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'b0010, 1, 16'h31, 1, 1, 16'h32, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'b0010, 1, 16'h32, 1, 1, 16'h33, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'b0010, 1, 16'h33, 1, 1, 16'h55, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'b0000, 1, 16'h55, 1, 1, 0, 0, 0));
    // Pop empty VC3 with same-cycle write: no bypass
    vecs.push_back(mk(1, 3, 16'h77, 1, 3, 4'b1000, 0, 0, 0, 3, 16'h77, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 3, 4'b0000, 1, 16'h77, 3, 3, 0, 0, 1));
    // Fill VC0, overflow, drain, then streaming write/pop across pointer wrap
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 16'(16'h10 + i), 0, 0, 4'b0001, 0, 0, 0, 0, 16'h10, 0, 1));
    vecs.push_back(mk(1, 0, 16'h14, 0, 0, 4'b0001, 0, 0, 0, 0, 16'h10, 1, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 1, 0, (i == 3) ? 4'b0000 : 4'b0001, 1, 16'(16'h10 + i), 0,
                        0, (i == 3) ? 16'h0 : 16'(16'h11 + i), 1, 1));
    vecs.push_back(mk(1, 0, 16'h20, 0, 0, 4'b0001, 0, 0, 0, 0, 16'h20, 1, 1));
    for (int i = 1; i < 8; i++)
      vecs.push_back(mk(1, 0, 16'(16'h20 + i), 1, 0, 4'b0001, 1, 16'(16'h20 + i - 1), 0,
                        0, 16'(16'h20 + i), 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 1, 16'h27, 0, 0, 0, 1, 1));

    in_valid = 1'b0; in_vc = '0; in_flit = '0; rd_valid = 1'b0; rd_vc = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Mid-stream reset: three VCs occupied and a pop's output/credit in flight
    step(mk(1, 0, 16'h40, 0, 0, 4'b0001, 0, 0, 0, 0, 16'h40, 1, 1), "mr0");
    step(mk(1, 1, 16'h41, 0, 0, 4'b0011, 0, 0, 0, 1, 16'h41, 1, 1), "mr1");
    step(mk(1, 2, 16'h42, 0, 0, 4'b0111, 0, 0, 0, 2, 16'h42, 1, 1), "mr2");
    step(mk(0, 0, 0, 1, 0, 4'b0110, 1, 16'h40, 0, 0, 0, 1, 1), "mr3");
    #2;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0), "post0");
    step(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2, 0, 0, 0), "post1");
    check_idle("post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
